// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin sharing of one valid/ready adder among N lanes,
//               with an in-order tag FIFO routing each sum back to its lane.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic [N-1:0]       rsp_valid,
    input  logic [N-1:0]       rsp_ready,
    output logic [N*WIDTH-1:0] rsp_data,
    output logic               A_valid,
    output logic               B_valid,
    input  logic               A_ready,
    input  logic               B_ready,
    output logic [WIDTH-1:0]   A_data,
    output logic [WIDTH-1:0]   B_data,
    input  logic               S_valid,
    output logic               S_ready,
    input  logic [WIDTH-1:0]   S_data
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(DEPTH - 1);
    localparam logic [IDW:0]    c_N        = (IDW+1)'(N);

    localparam logic [0:0] c_ST_OPEN   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_lgnt;
    logic [IDW-1:0]  r_fifo [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic [IDW-1:0]  w_scan_gnt;
    logic            w_scan_hit;
    logic [IDW-1:0]  w_grant;
    logic            w_avalid;
    logic            w_issue;
    logic            w_pop;
    logic            w_fifo_ne;
    logic [IDW-1:0]  w_head_tag;

    // Lane index base+off, wrapping at N-1 back to 0.
    function automatic logic [IDW-1:0] f_lane(input logic [IDW-1:0] base,
                                              input logic [IDW-1:0] off);
        logic [IDW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= c_N)
            s = s - c_N;
        return s[IDW-1:0];
    endfunction

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PW'(1);
    endfunction

    always_comb begin
        w_scan_gnt = r_ptr;
        w_scan_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_scan_hit && req_valid[f_lane(r_ptr, IDW'(i))]) begin
                w_scan_hit = 1'b1;
                w_scan_gnt = f_lane(r_ptr, IDW'(i));
            end
        end
    end

    // A stalled offer keeps its lane so the adder sees stable operands.
    assign w_grant    = (r_state == c_ST_LOCKED) ? r_lgnt : w_scan_gnt;
    assign w_avalid   = !reset && req_valid[w_grant] && (r_count < c_DEPTH);
    assign w_issue    = w_avalid && A_ready && B_ready;
    assign w_fifo_ne  = (r_count != '0);
    assign w_head_tag = r_fifo[r_head];
    assign w_pop      = S_valid && S_ready;

    // Lock state machine: register / next-state / outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_ST_OPEN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_issue)
            w_state_nxt = c_ST_OPEN;
        else if (w_avalid)
            w_state_nxt = c_ST_LOCKED;
    end

    always_comb begin
        A_valid   = w_avalid;
        B_valid   = w_avalid;
        A_data    = '0;
        B_data    = '0;
        req_ready = '0;
        rsp_valid = '0;
        S_ready   = 1'b0;
        rsp_data  = '0;
        if (!reset) begin
            A_data   = req_a[w_grant*WIDTH +: WIDTH];
            B_data   = req_b[w_grant*WIDTH +: WIDTH];
            rsp_data = {N{S_data}};
            if (w_issue)
                req_ready[w_grant] = 1'b1;
            if (w_fifo_ne) begin
                rsp_valid[w_head_tag] = S_valid;
                S_ready               = rsp_ready[w_head_tag];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_lgnt  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_fifo[i] <= '0;
        end else begin
            if (w_issue) begin
                r_ptr          <= f_lane(w_grant, IDW'(1));
                r_fifo[r_tail] <= w_grant;
                r_tail         <= f_next(r_tail);
            end else if (w_avalid) begin
                r_lgnt <= w_grant;
            end
            if (w_pop)
                r_head <= f_next(r_head);
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed bench for adder_arbiter with a one-register adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int c_SEQ [12] = '{3, 0, 2, 1, 1, 3, 0, 0, 2, 3, 1, 2};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b, rsp_data;
    logic        A_valid, B_valid, A_ready, B_ready, S_valid, S_ready;
    logic [7:0]  A_data, B_data, S_data;
    logic        stall;
    logic        add_v;
    logic [7:0]  add_s;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(8), .N(4), .IDW(2), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .A_valid(A_valid), .B_valid(B_valid),
        .A_ready(A_ready), .B_ready(B_ready),
        .A_data(A_data), .B_data(B_data),
        .S_valid(S_valid), .S_ready(S_ready), .S_data(S_data)
    );

    // Shared adder: one result register, resets with the arbiter.
    assign A_ready = !stall && (!add_v || S_ready);
    assign B_ready = A_ready;
    assign S_valid = add_v;
    assign S_data  = add_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_v <= 1'b0;
            add_s <= 8'h00;
        end else begin
            if (S_valid && S_ready)
                add_v <= 1'b0;
            if (A_valid && A_ready && B_valid && B_ready) begin
                add_v <= 1'b1;
                add_s <= A_data + B_data;
            end
        end
    end

    task automatic set_lane(input int l, input logic [7:0] a, input logic [7:0] b);
        req_a[l*8 +: 8] = a;
        req_b[l*8 +: 8] = b;
    endtask

    // One clock; accepted requests drop their valid like a real requester.
    task automatic advance();
        logic [3:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        req_valid = 4'hF;
        req_a = 32'h44332211;
        req_b = 32'h88776655;
        #1;
        n_cmp++; if (A_valid !== 1'b0 || B_valid !== 1'b0) begin n_err++; $display("FAIL rst_avalid: got %b%b want 00", A_valid, B_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000 || S_ready !== 1'b0) begin n_err++; $display("FAIL rst_rsp: got %b/%b want 0000/0", rsp_valid, S_ready); end
        n_cmp++; if (A_data !== 8'h00 || B_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h/%h want 00/00", A_data, B_data); end
        req_valid = 4'h0;
        reset = 1'b0;
        advance();
        #1;
        n_cmp++; if (A_valid !== 1'b0) begin n_err++; $display("FAIL idle_avalid: got %b want 0", A_valid); end
    endtask

    task automatic test_single();
        set_lane(2, 8'd3, 8'd4);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        n_cmp++; if (A_valid !== 1'b1 || A_data !== 8'd3 || B_data !== 8'd4) begin n_err++; $display("FAIL single_issue: got %b %h %h want 1 03 04", A_valid, A_data, B_data); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data[23:16] !== 8'd7) begin n_err++; $display("FAIL single_rsp: got %b %h want 0100 07", rsp_valid, rsp_data[23:16]); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_pulse: got %b want 0000", req_ready); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_pop: got %b want 0000", rsp_valid); end
        // ptr is now 3: lane 3 must beat lane 0, then ptr wraps to 0
        set_lane(0, 8'd10, 8'd1);
        set_lane(3, 8'd30, 8'd1);
        req_valid = 4'b1001;
        #1;
        n_cmp++; if (req_ready !== 4'b1000 || A_data !== 8'd30) begin n_err++; $display("FAIL ptr3_grant: got %b %h want 1000 1e", req_ready, A_data); end
        advance(); #1;
        n_cmp++; if (req_ready !== 4'b0001 || A_data !== 8'd10) begin n_err++; $display("FAIL ptr_wrap: got %b %h want 0001 0a", req_ready, A_data); end
        n_cmp++; if (rsp_valid !== 4'b1000 || rsp_data[31:24] !== 8'd31) begin n_err++; $display("FAIL wrap_rsp3: got %b %h want 1000 1f", rsp_valid, rsp_data[31:24]); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd11) begin n_err++; $display("FAIL wrap_rsp0: got %b %h want 0001 0b", rsp_valid, rsp_data[7:0]); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [7:0] sums [4];
        int g;
        int p;
        // ptr is 1; a lone lane-3 issue brings it back to 0
        set_lane(3, 8'd0, 8'd0);
        req_valid = 4'b1000;
        advance();
        advance();
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 8'((i + 1) * 16), 8'(i + 1));
            sums[i] = 8'((i + 1) * 17);
        end
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b1111;
            #1;
            g = k % 4;
            n_cmp++; if (req_ready !== 4'(1 << g)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << g)); end
            if (k > 0) begin
                p = (k - 1) % 4;
                n_cmp++; if (rsp_valid !== 4'(1 << p) || rsp_data[p*8 +: 8] !== sums[p]) begin n_err++; $display("FAIL rr_rsp%0d: got %b %h want %b %h", k, rsp_valid, rsp_data[p*8 +: 8], 4'(1 << p), sums[p]); end
            end
            advance();
        end
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'h11) begin n_err++; $display("FAIL rr_last: got %b %h want 0001 11", rsp_valid, rsp_data[7:0]); end
        advance();
    endtask

    task automatic test_backpressure();
        set_lane(1, 8'hFF, 8'h02);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_issue1: got %b want 0010", req_ready); end
        advance();
        rsp_ready = 4'b1101;
        set_lane(0, 8'd5, 8'd6);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0010 || S_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold: got %b %b want 0010 0", rsp_valid, S_ready); end
        n_cmp++; if (A_valid !== 1'b1 || req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_block0: got %b %b want 1 0000", A_valid, req_ready); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data[15:8] !== 8'h01 || req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stable: got %b %h %b want 0010 01 0000", rsp_valid, rsp_data[15:8], req_ready); end
        rsp_ready = 4'b1111;
        #1;
        n_cmp++; if (S_ready !== 1'b1 || req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release: got %b %b want 1 0001", S_ready, req_ready); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'h0B) begin n_err++; $display("FAIL bp_rsp0: got %b %h want 0001 0b", rsp_valid, rsp_data[7:0]); end
        advance();
    endtask

    task automatic test_lock();
        // ptr is 1; a lone lane-1 issue moves it to 2
        set_lane(1, 8'd1, 8'd1);
        req_valid = 4'b0010;
        advance();
        advance();
        stall = 1'b1;
        set_lane(3, 8'h30, 8'h03);
        set_lane(2, 8'h20, 8'h02);
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (A_valid !== 1'b1 || A_data !== 8'h30 || req_ready !== 4'b0000) begin n_err++; $display("FAIL lock_offer: got %b %h %b want 1 30 0000", A_valid, A_data, req_ready); end
        advance();
        req_valid = 4'b1100;
        #1;
        n_cmp++; if (A_data !== 8'h30 || B_data !== 8'h03) begin n_err++; $display("FAIL lock_hold: got %h %h want 30 03", A_data, B_data); end
        advance(); #1;
        n_cmp++; if (A_data !== 8'h30 || req_ready !== 4'b0000) begin n_err++; $display("FAIL lock_hold2: got %h %b want 30 0000", A_data, req_ready); end
        stall = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL lock_accept: got %b want 1000", req_ready); end
        advance(); #1;
        n_cmp++; if (req_ready !== 4'b0100 || A_data !== 8'h20) begin n_err++; $display("FAIL lock_next2: got %b %h want 0100 20", req_ready, A_data); end
        n_cmp++; if (rsp_valid !== 4'b1000 || rsp_data[31:24] !== 8'h33) begin n_err++; $display("FAIL lock_rsp3: got %b %h want 1000 33", rsp_valid, rsp_data[31:24]); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data[23:16] !== 8'h22) begin n_err++; $display("FAIL lock_rsp2: got %b %h want 0100 22", rsp_valid, rsp_data[23:16]); end
        advance();
    endtask

    task automatic test_reset_midflight();
        // ptr is 3; lane 1 is the only requester
        set_lane(1, 8'd7, 8'd8);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_issue: got %b want 0010", req_ready); end
        advance();
        reset = 1'b1;
        set_lane(0, 8'd1, 8'd2);
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0000 || S_ready !== 1'b0 || rsp_data !== 32'h0) begin n_err++; $display("FAIL mid_rsp_clear: got %b %b %h want 0000 0 0", rsp_valid, S_ready, rsp_data); end
        n_cmp++; if (A_valid !== 1'b0 || req_ready !== 4'b0000 || A_data !== 8'h00) begin n_err++; $display("FAIL mid_req_clear: got %b %b %h want 0 0000 00", A_valid, req_ready, A_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_orphan: got %b want 0000", rsp_valid); end
        n_cmp++; if (req_ready !== 4'b0001 || A_data !== 8'd1) begin n_err++; $display("FAIL mid_first0: got %b %h want 0001 01", req_ready, A_data); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd3 || req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_rsp0: got %b %h %b want 0001 03 0010", rsp_valid, rsp_data[7:0], req_ready); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data[15:8] !== 8'd15) begin n_err++; $display("FAIL mid_rsp1: got %b %h want 0010 0f", rsp_valid, rsp_data[15:8]); end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] prev_s;
        int         l;
        int         prev_l;
        prev_s = 8'h00;
        prev_l = 0;
        for (int k = 0; k < 12; k++) begin
            l = c_SEQ[k];
            a = 8'(k * 16 + l);
            set_lane(l, a, 8'hF0);
            req_valid = 4'(1 << l);
            #1;
            n_cmp++; if (req_ready !== 4'(1 << l)) begin n_err++; $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, 4'(1 << l)); end
            if (k > 0) begin
                n_cmp++; if (rsp_valid !== 4'(1 << prev_l) || rsp_data[prev_l*8 +: 8] !== prev_s) begin n_err++; $display("FAIL b2b_rsp%0d: got %b %h want %b %h", k, rsp_valid, rsp_data[prev_l*8 +: 8], 4'(1 << prev_l), prev_s); end
            end
            prev_s = a + 8'hF0;
            prev_l = l;
            advance();
        end
        #1;
        n_cmp++; if (rsp_valid !== 4'(1 << prev_l) || rsp_data[prev_l*8 +: 8] !== prev_s) begin n_err++; $display("FAIL b2b_last: got %b %h want %b %h", rsp_valid, rsp_data[prev_l*8 +: 8], 4'(1 << prev_l), prev_s); end
        advance(); #1;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_drain: got %b want 0000", rsp_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 4'h0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 4'hF;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
